adc_axil_arbiter: RTL and testbench

Round-robin arbiter that shares the single AXI4-Lite master port of the ADC register slave (`ADC_AXI`, four 32-bit registers at offsets 0x0/0x4/0x8/0xC) between up to eight on-chip requesters, such as configuration logic and a sample poller. Each requester issues one single-beat read or write at a time over a simple req/done interface. The arbiter serialises these requests into AXI4-Lite transactions and returns read data and response codes. It sits between the requesters and the ADC slave's `S_AXI` port, in the same `ACLK` domain.

---
 rtl/adc_axil_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/adc_axil_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_adc_axil_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_axil_pkg.sv
// rtl/adc_axil_pkg.sv - shared types and constants for the ADC AXI4-Lite arbiter
// Purpose: FSM state encoding, AXI response codes and ADC register offsets.
// Ports: none (package).
package adc_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] ADC_REG0_OFFSET = 32'h0;
    localparam logic [31:0] ADC_REG1_OFFSET = 32'h4;
    localparam logic [31:0] ADC_REG2_OFFSET = 32'h8;
    localparam logic [31:0] ADC_REG3_OFFSET = 32'hC;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Purpose: pick the first requesting index strictly after last_i, wrapping.
// Ports: req_i request vector, last_i previous grant index,
//        gnt_o one-hot grant (all zero when idle), gnt_idx_o grant index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        logic          found;
        int            pos;
        logic [IW-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        // Scan last+1 .. last+NUM_REQ so the previous winner is checked last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            pos = int'(last_i) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IW'(pos);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/adc_axil_arbiter.sv
// rtl/adc_axil_arbiter.sv - round-robin sharing of one AXI4-Lite master port
// Purpose: serialise single-beat req/done transactions from NUM_REQ requesters
//          onto the ADC register slave's AXI4-Lite port.
// Ports: req/req_we/req_addr/req_wdata/req_wstrb packed per requester;
//        done one-cycle pulse per requester with rdata/resp; busy when not idle;
//        M_AXI_* AXI4-Lite master channels AW, W, B, AR, R.
module adc_axil_arbiter
    import adc_axil_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                                       ACLK,
    input  logic                                       ARESETN,
    input  logic [NUM_REQ-1:0]                         req,
    input  logic [NUM_REQ-1:0]                         req_we,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(C_M_AXI_DATA_WIDTH/8)-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]                         done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]              rdata,
    output logic [1:0]                                 resp,
    output logic                                       busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
    output logic [2:0]                                 M_AXI_AWPROT,
    output logic                                       M_AXI_AWVALID,
    input  logic                                       M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
    output logic                                       M_AXI_WVALID,
    input  logic                                       M_AXI_WREADY,
    input  logic [1:0]                                 M_AXI_BRESP,
    input  logic                                       M_AXI_BVALID,
    output logic                                       M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
    output logic [2:0]                                 M_AXI_ARPROT,
    output logic                                       M_AXI_ARVALID,
    input  logic                                       M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
    input  logic [1:0]                                 M_AXI_RRESP,
    input  logic                                       M_AXI_RVALID,
    output logic                                       M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;
    logic [SW-1:0]       sel_wstrb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign sel_addr  = req_addr[int'(arb_idx)*AW +: AW];
    assign sel_wdata = req_wdata[int'(arb_idx)*DW +: DW];
    assign sel_wstrb = req_wstrb[int'(arb_idx)*SW +: SW];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            gnt_oh_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_oh_q  <= gnt_oh_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_oh_d  = gnt_oh_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    last_d   = arb_idx;
                    gnt_oh_d = arb_gnt;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    wstrb_d  = sel_wstrb;
                    if (req_we[arb_idx]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; leave once both are gone.
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    // BREADY is already high here, so an early B beat is taken now.
                    if (M_AXI_BVALID) begin
                        rdata_d = '0;
                        resp_d  = M_AXI_BRESP;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (M_AXI_BVALID) begin
                    rdata_d = '0;
                    resp_d  = M_AXI_BRESP;
                    state_d = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done          = (state_q == ST_DONE) ? gnt_oh_q : '0;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign busy          = (state_q != ST_IDLE);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WRITE) || (state_q == ST_WRESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_adc_axil_arbiter.sv
// tb/tb_adc_axil_arbiter.sv - self-checking bench for adc_axil_arbiter with a 4-register slave model
module tb_adc_axil_arbiter;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [N-1:0] oh;
        logic [31:0]  rdata;
        logic [1:0]   resp;
    } sb_t;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [N-1:0]    req, req_we;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [N-1:0]    done;
    logic [31:0]     rdata;
    logic [1:0]      resp;
    logic            busy;
    logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int persist_left = 0;
    sb_t sb_q[$];
    sb_t mon_e;
    vec_t vecs[13];

    // slave model state
    logic [31:0] mem [4];
    logic        aw_got, w_got, b_pend, r_pend;
    int          aw_cnt, w_cnt, r_cnt;
    int          aw_delay = 0, w_delay = 0, r_delay = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    adc_axil_arbiter #(
        .NUM_REQ            (N),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .done          (done),
        .rdata         (rdata),
        .resp          (resp),
        .busy          (busy),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input int idx, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
        vec_t v;
        v.idx = idx; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
        return v;
    endfunction

    // Slave: all handshake inputs change on the falling edge only.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
            M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
            M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            aw_cnt = 0; w_cnt = 0; r_cnt = 0;
            for (int i = 0; i < 4; i++) mem[i] = '0;
        end else begin
            M_AXI_BVALID = 1'b0;
            if (b_pend && M_AXI_BREADY) begin
                M_AXI_BVALID = 1'b1;
                b_pend = 1'b0;
                if (s_awaddr < 32'h10) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    M_AXI_BRESP = 2'b00;
                end else begin
                    M_AXI_BRESP = 2'b11;
                end
            end
            M_AXI_RVALID = 1'b0;
            if (r_pend && M_AXI_RREADY) begin
                if (r_cnt >= r_delay) begin
                    M_AXI_RVALID = 1'b1;
                    r_pend = 1'b0;
                    r_cnt = 0;
                    if (s_araddr < 32'h10) begin
                        M_AXI_RDATA = mem[s_araddr[3:2]]; M_AXI_RRESP = 2'b00;
                    end else begin
                        M_AXI_RDATA = '0; M_AXI_RRESP = 2'b10;
                    end
                end else begin
                    r_cnt++;
                end
            end
            M_AXI_AWREADY = 1'b0;
            if (M_AXI_AWVALID && !aw_got) begin
                if (aw_cnt >= aw_delay) begin
                    M_AXI_AWREADY = 1'b1; aw_got = 1'b1; aw_cnt = 0; s_awaddr = M_AXI_AWADDR;
                end else aw_cnt++;
            end
            M_AXI_WREADY = 1'b0;
            if (M_AXI_WVALID && !w_got) begin
                if (w_cnt >= w_delay) begin
                    M_AXI_WREADY = 1'b1; w_got = 1'b1; w_cnt = 0;
                    s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB;
                end else w_cnt++;
            end
            if (aw_got && w_got) begin
                b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0;
            end
            M_AXI_ARREADY = 1'b0;
            if (M_AXI_ARVALID && !r_pend) begin
                M_AXI_ARREADY = 1'b1; r_pend = 1'b1; s_araddr = M_AXI_ARADDR;
            end
        end
    end

    // Scoreboard: every done pulse is matched against the next expected record.
    always @(negedge ACLK) begin
        if (ARESETN && done != '0) begin
            done_count++;
            if (sb_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_grant", 64'(done), 64'(mon_e.oh));
                check("done_rdata", 64'(rdata), 64'(mon_e.rdata));
                check("done_resp", 64'(resp), 64'(mon_e.resp));
            end
            if (persist_left > 0) begin
                persist_left--;
                if (persist_left == 0) req = '0;
            end else begin
                req = req & ~done;
            end
        end
    end

    task automatic issue(input vec_t v, input bit expect_done);
        req_we[v.idx]             = v.we;
        req_addr[v.idx*32 +: 32]  = v.addr;
        req_wdata[v.idx*32 +: 32] = v.wdata;
        req_wstrb[v.idx*4 +: 4]   = v.wstrb;
        if (expect_done) sb_q.push_back('{oh: 4'(1 << v.idx), rdata: v.exp_rdata, resp: v.exp_resp});
        req[v.idx] = 1'b1;
    endtask

    // Returns #1 after the edge that leaves DONE.
    task automatic wait_dones(input int target, input string name);
        int n;
        n = 0;
        while (done_count < target && n < 200) begin
            @(posedge ACLK);
            n++;
        end
        check(name, 64'(done_count >= target), 64'h1);
        #1;
    endtask

    task automatic post_idle(input string name);
        check({name, "_done_low"}, 64'(done), 64'h0);
        check({name, "_idle"}, 64'(busy), 64'h0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int target;
        target = done_count + 1;
        @(posedge ACLK); #1;
        issue(v, 1'b1);
        wait_dones(target, {name, "_timeout"});
        post_idle(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                    M_AXI_RREADY, busy, done, resp}), 64'h0);
        check({name, "_rdata"}, 64'(rdata), 64'h0);
        check({name, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
        check({name, "_wdata"}, 64'({M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 64'h0);
    endtask

    // Write with one channel stalled; the other VALID must drop on its own handshake.
    task automatic skew_write(input vec_t v, input bit aw_slow, input string name);
        int target, n;
        bit saw;
        target = done_count + 1;
        saw = 1'b0;
        aw_delay = aw_slow ? 3 : 0;
        w_delay  = aw_slow ? 0 : 3;
        @(posedge ACLK); #1;
        issue(v, 1'b1);
        n = 0;
        while (n < 20) begin
            @(posedge ACLK); #1;
            n++;
            if (aw_slow && !M_AXI_WVALID && M_AXI_AWVALID) saw = 1'b1;
            if (!aw_slow && !M_AXI_AWVALID && M_AXI_WVALID) saw = 1'b1;
            if (!M_AXI_AWVALID && !M_AXI_WVALID) break;
        end
        check({name, "_independent_drop"}, 64'(saw), 64'h1);
        wait_dones(target, {name, "_timeout"});
        post_idle(name);
        aw_delay = 0;
        w_delay  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int target, n;
        vecs[0]  = mk(0, 1'b1, 32'h0,  32'h0101FFFF, 4'hF, 32'h0, 2'b00);
        vecs[1]  = mk(0, 1'b1, 32'h4,  32'hABCD0001, 4'hF, 32'h0, 2'b00);
        vecs[2]  = mk(0, 1'b1, 32'h8,  32'hDEAD0011, 4'hF, 32'h0, 2'b00);
        vecs[3]  = mk(0, 1'b1, 32'hC,  32'hBEEF0011, 4'hF, 32'h0, 2'b00);
        vecs[4]  = mk(0, 1'b0, 32'h0,  32'h0, 4'h0, 32'h0101FFFF, 2'b00);
        vecs[5]  = mk(0, 1'b0, 32'h4,  32'h0, 4'h0, 32'hABCD0001, 2'b00);
        vecs[6]  = mk(0, 1'b0, 32'h8,  32'h0, 4'h0, 32'hDEAD0011, 2'b00);
        vecs[7]  = mk(0, 1'b0, 32'hC,  32'h0, 4'h0, 32'hBEEF0011, 2'b00);
        vecs[8]  = mk(0, 1'b1, 32'h8,  32'h12345678, 4'h3, 32'h0, 2'b00);
        vecs[9]  = mk(0, 1'b0, 32'h8,  32'h0, 4'h0, 32'hDEAD5678, 2'b00);
        vecs[10] = mk(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b10);
        vecs[11] = mk(1, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b11);
        vecs[12] = mk(3, 1'b0, 32'hC,  32'h0, 4'h0, 32'hBEEF0011, 2'b00);

        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESETN = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Requesters 0 and 1 in the same cycle; pointer sits at 3, so 0 wins.
        target = done_count + 2;
        @(posedge ACLK); #1;
        issue(mk(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 2'b00), 1'b1);
        issue(mk(1, 1'b1, 32'h0, 32'h22222222, 4'hF, 32'h0, 2'b00), 1'b1);
        wait_dones(target, "simul_timeout");
        post_idle("simul");
        run_vec(mk(3, 1'b0, 32'h0, 32'h0, 4'h0, 32'h22222222, 2'b00), "simul_readback");

        // All four hold req across eight transactions.
        target = done_count + 8;
        @(posedge ACLK); #1;
        persist_left = 8;
        for (int r = 0; r < 2; r++) begin
            sb_q.push_back('{oh: 4'b0001, rdata: 32'h22222222, resp: 2'b00});
            sb_q.push_back('{oh: 4'b0010, rdata: 32'hABCD0001, resp: 2'b00});
            sb_q.push_back('{oh: 4'b0100, rdata: 32'hDEAD5678, resp: 2'b00});
            sb_q.push_back('{oh: 4'b1000, rdata: 32'hBEEF0011, resp: 2'b00});
        end
        for (int i = 0; i < N; i++) issue(mk(i, 1'b0, 32'(4 * i), 32'h0, 4'h0, 32'h0, 2'b00), 1'b0);
        wait_dones(target, "persist_timeout");
        post_idle("persist");

        skew_write(mk(1, 1'b1, 32'h4, 32'h5A5A0001, 4'hF, 32'h0, 2'b00), 1'b1, "skew_aw");
        run_vec(mk(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h5A5A0001, 2'b00), "skew_aw_readback");
        skew_write(mk(2, 1'b1, 32'h8, 32'hA5A50002, 4'hF, 32'h0, 2'b00), 1'b0, "skew_w");
        run_vec(mk(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'hA5A50002, 2'b00), "skew_w_readback");

        // Reset while the read is parked in RDATA.
        r_delay = 5;
        @(posedge ACLK); #1;
        issue(mk(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00), 1'b0);
        n = 0;
        while (!M_AXI_RREADY && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("midread_reached_rdata", 64'(M_AXI_RREADY), 64'h1);
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        req = '0;
        #1;
        check_reset_outputs("midread_reset");
        repeat (2) @(posedge ACLK);
        r_delay = 0;
        #1;
        ARESETN = 1'b1;
        target = done_count + 2;
        @(posedge ACLK); #1;
        issue(mk(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00), 1'b1);
        issue(mk(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 2'b00), 1'b1);
        wait_dones(target, "after_reset_timeout");
        post_idle("after_reset");
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
